// File: rtl/rx_comma_align.sv
// Serial 10b receiver front end: finds K28.5 commas in the bit stream, frames
// 10b symbols on the aligned boundary and tracks sync with a three-state FSM.
module rx_comma_align #(
  parameter int COMMAS_TO_SYNC = 3,
  parameter int ERRS_TO_LOSS   = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ENB,
  input  logic       in_serial,
  output logic [9:0] out_paralelo,
  output logic       valid,
  output logic       comma_det,
  output logic       sync
);

  localparam logic [1:0] ST_LOSS_OF_SYNC = 2'd0;
  localparam logic [1:0] ST_COMMA_DET    = 2'd1;
  localparam logic [1:0] ST_SYNC         = 2'd2;

  localparam int CCW = (COMMAS_TO_SYNC < 2) ? 1 : $clog2(COMMAS_TO_SYNC + 1);
  localparam int ECW = (ERRS_TO_LOSS < 2) ? 1 : $clog2(ERRS_TO_LOSS + 1);
  localparam logic [CCW-1:0] COMMA_TGT = CCW'(COMMAS_TO_SYNC);
  localparam logic [ECW-1:0] ERR_TGT   = ECW'(ERRS_TO_LOSS);

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  // Only the nine most recent bits are kept; the oldest bit of the window
  // would never be read again once the new bit is shifted in.
  logic [8:0]     sr;
  logic [9:0]     sr_n;
  logic [3:0]     bit_cnt;
  logic [CCW-1:0] comma_cnt;
  logic [ECW-1:0] err_cnt;
  logic [1:0]     state;

  logic           is_comma;
  logic           invalid;
  logic           boundary;
  logic [3:0]     ones;
  logic [CCW-1:0] comma_inc;
  logic [ECW-1:0] err_inc;

  function automatic logic [3:0] count_ones(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign sr_n      = {sr, in_serial};
  assign is_comma  = (sr_n == K28_5_RDN) || (sr_n == K28_5_RDP);
  assign ones      = count_ones(sr_n);
  assign invalid   = (ones < 4'd4) || (ones > 4'd6);
  assign boundary  = (bit_cnt == 4'd9);
  assign comma_inc = comma_cnt + 1'b1;
  assign err_inc   = err_cnt + 1'b1;
  assign sync      = (state == ST_SYNC);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of bit_cnt, counters and state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sr           <= '0;
      bit_cnt      <= '0;
      comma_cnt    <= '0;
      err_cnt      <= '0;
      state        <= ST_LOSS_OF_SYNC;
      out_paralelo <= '0;
      valid        <= 1'b0;
      comma_det    <= 1'b0;
    end else begin
      valid     <= 1'b0;
      comma_det <= 1'b0;
      if (ENB) begin
        sr      <= sr_n[8:0];
        bit_cnt <= boundary ? 4'd0 : bit_cnt + 4'd1;
        case (state)
          ST_LOSS_OF_SYNC: begin
            // A comma anywhere realigns the symbol counter to this bit.
            if (is_comma) begin
              bit_cnt      <= 4'd0;
              out_paralelo <= sr_n;
              valid        <= 1'b1;
              comma_det    <= 1'b1;
              comma_cnt    <= CCW'(1);
              state        <= (COMMAS_TO_SYNC == 1) ? ST_SYNC : ST_COMMA_DET;
            end
          end
          ST_COMMA_DET: begin
            if (boundary) begin
              out_paralelo <= sr_n;
              valid        <= 1'b1;
              comma_det    <= is_comma;
              if (is_comma) begin
                comma_cnt <= comma_inc;
                if (comma_inc == COMMA_TGT) state <= ST_SYNC;
              end else if (invalid) begin
                comma_cnt <= '0;
                state     <= ST_LOSS_OF_SYNC;
              end
            end
          end
          ST_SYNC: begin
            if (boundary) begin
              out_paralelo <= sr_n;
              valid        <= 1'b1;
              comma_det    <= is_comma;
              if (!invalid) begin
                err_cnt <= '0;
              end else if (err_inc == ERR_TGT) begin
                err_cnt   <= '0;
                comma_cnt <= '0;
                state     <= ST_LOSS_OF_SYNC;
              end else begin
                err_cnt <= err_inc;
              end
            end
          end
          default: state <= ST_LOSS_OF_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_comma_align.sv
// Directed bench for rx_comma_align: alignment, sync acquisition and loss,
// enable stall and mid-stream reset, with hand-computed expected symbols.
module tb_rx_comma_align;

  logic       CLK = 1'b0;
  logic       reset;
  logic       ENB;
  logic       in_serial;
  logic [9:0] out_paralelo;
  logic       valid;
  logic       comma_det;
  logic       sync;

  localparam logic [1:0] ST_LOS = 2'd0;
  localparam logic [1:0] ST_CD  = 2'd1;

  int n_checks = 0;
  int n_errors = 0;

  int         ecount;
  int         first_valid;
  int         nval;
  int         ncd;
  int         vpos;
  int         consec;
  logic       prev_valid;
  logic [9:0] last_sym;

  rx_comma_align #(.COMMAS_TO_SYNC(3), .ERRS_TO_LOSS(4)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .ENB         (ENB),
    .in_serial   (in_serial),
    .out_paralelo(out_paralelo),
    .valid       (valid),
    .comma_det   (comma_det),
    .sync        (sync)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given bit and enable; outputs sampled 1 ns after the edge.
  task automatic step(input logic b, input logic en);
    in_serial = b;
    ENB       = en;
    @(posedge CLK);
    #1;
    if (en) ecount++;
    if (valid && prev_valid) consec++;
    prev_valid = valid;
    if (valid) begin
      nval++;
      last_sym = out_paralelo;
      if (first_valid == 0) first_valid = ecount;
    end
    if (comma_det) ncd++;
  endtask

  // Sends one symbol MSB first; reports pulses and the bit index of the valid.
  task automatic send_sym(input logic [9:0] sym, output int nv, output int nc, output int pos);
    nval = 0;
    ncd  = 0;
    pos  = -1;
    for (int i = 0; i < 10; i++) begin
      step(sym[9-i], 1'b1);
      if (valid) pos = i;
    end
    nv = nval;
    nc = ncd;
  endtask

  int nv, nc, pos;
  logic [3:0] bc_before;

  initial begin
    reset = 1'b1; ENB = 1'b0; in_serial = 1'b0;
    prev_valid = 1'b0; consec = 0; last_sym = '0;
    #2 reset = 1'b0;
    #5;
    check("rst_out", out_paralelo, 10'h000);
    check("rst_valid", valid, 1'b0);
    check("rst_comma", comma_det, 1'b0);
    check("rst_sync", sync, 1'b0);
    @(negedge CLK);
    reset = 1'b1;

    // Junk 101 then K28.5 RD-: first valid on the 13th enabled edge.
    ecount = 0; first_valid = 0; nval = 0; ncd = 0;
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    send_sym(10'h0FA, nv, nc, pos);
    check("align_edge", first_valid, 13);
    check("align_sym", last_sym, 10'h0FA);
    check("align_comma", nc, 1);
    check("align_state", dut.state, ST_CD);

    // Two more aligned commas reach sync on the third.
    send_sym(10'h0FA, nv, nc, pos);
    check("c2_pos", pos, 9);
    check("c2_sync", sync, 1'b0);
    check("c2_cnt", dut.comma_cnt, 2);
    send_sym(10'h305, nv, nc, pos);
    check("c3_sym", last_sym, 10'h305);
    check("c3_sync", sync, 1'b1);
    send_sym(10'h2AA, nv, nc, pos);
    check("d21_sym", last_sym, 10'h2AA);
    check("d21_nv", nv, 1);
    check("d21_pos", pos, 9);
    check("d21_cd", nc, 0);

    // Three invalids then a valid symbol: sync must survive.
    for (int k = 0; k < 3; k++) send_sym(10'h003, nv, nc, pos);
    check("inv3_sym", last_sym, 10'h003);
    check("inv3_sync", sync, 1'b1);
    send_sym(10'h2AA, nv, nc, pos);
    check("recover_sync", sync, 1'b1);
    check("recover_err", dut.err_cnt, 0);

    // Four consecutive invalids drop sync after the fourth.
    for (int k = 0; k < 3; k++) send_sym(10'h003, nv, nc, pos);
    check("inv_3of4_sync", sync, 1'b1);
    send_sym(10'h003, nv, nc, pos);
    check("inv_4of4_sync", sync, 1'b0);
    check("inv_4of4_state", dut.state, ST_LOS);

    // Re-search with RD+ comma, then an invalid symbol in COMMA_DET.
    send_sym(10'h305, nv, nc, pos);
    check("realign_pos", pos, 9);
    check("realign_sym", last_sym, 10'h305);
    check("realign_state", dut.state, ST_CD);
    send_sym(10'h3FF, nv, nc, pos);
    check("cd_inv_sym", last_sym, 10'h3FF);
    check("cd_inv_state", dut.state, ST_LOS);
    check("cd_inv_cnt", dut.comma_cnt, 0);

    // Realign, then stall ENB for 7 cycles in the middle of D21.5.
    send_sym(10'h0FA, nv, nc, pos);
    check("stall_align", last_sym, 10'h0FA);
    nval = 0;
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    bc_before = dut.bit_cnt;
    for (int k = 0; k < 7; k++) step(k[0], 1'b0);
    check("stall_bitcnt", dut.bit_cnt, bc_before);
    check("stall_nv", nval, 0);
    for (int k = 0; k < 6; k++) step(k[0] ? 1'b0 : 1'b1, 1'b1);
    check("stall_sym", last_sym, 10'h2AA);
    check("stall_nv_done", nval, 1);

    // Mid-symbol reset clears everything; alignment restarts from scratch.
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_out", out_paralelo, 10'h000);
    check("mid_rst_bitcnt", dut.bit_cnt, 0);
    check("mid_rst_state", dut.state, ST_LOS);
    @(negedge CLK);
    reset = 1'b1;
    ecount = 0; first_valid = 0; nval = 0; ncd = 0;
    step(1'b0, 1'b1); step(1'b1, 1'b1);
    send_sym(10'h0FA, nv, nc, pos);
    check("rst_realign_edge", first_valid, 12);
    check("rst_realign_sym", last_sym, 10'h0FA);

    check("no_consec_valid", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_comma_align.md
RX_COMMA_ALIGN -- requirements
Module: rx_comma_align

Interface
REQ-001 Parameter: COMMAS_TO_SYNC, 3, aligned commas (including the first) needed to declare sync.
REQ-002 Parameter: ERRS_TO_LOSS, 4, consecutive invalid symbols in SYNC that force loss of sync.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: ENB  input  1  bit enable; when low, all state holds.
REQ-006 Port: in_serial  input  1  serial 10b line bit; bit a (symbol bit 9) arrives first.
REQ-007 Port: out_paralelo  output  10  last delineated 10b symbol, {a,b,c,d,e,i,f,g,h,j} = bits 9..0.
REQ-008 Port: valid  output  1  one-cycle strobe: out_paralelo updated this cycle.
REQ-009 Port: comma_det  output  1  one-cycle strobe: delivered symbol is K28.5.
REQ-010 Port: sync  output  1  high while FSM is in SYNC.

Function
REQ-011 The block SHALL keep a 10-bit shift register sr; on each CLK edge with ENB=1, sr_n = {sr[8:0], in_serial} is loaded.
REQ-012 A comma SHALL be sr_n equal to 10'b0011111010 (RD-) or 10'b1100000101 (RD+).
REQ-013 A symbol SHALL be invalid when its count of ones is not 4, 5 or 6.
REQ-014 A 4-bit bit_cnt SHALL count 0..9 and wrap 9->0 on each enabled edge, except where REQ-016 realigns it.
REQ-015 FSM states SHALL be LOSS_OF_SYNC, COMMA_DET, SYNC.
REQ-016 In LOSS_OF_SYNC, on any enabled edge where sr_n is a comma (at any bit position), the block SHALL set bit_cnt to 0, load out_paralelo = sr_n, pulse valid and comma_det, set comma_cnt to 1, and go to COMMA_DET (or directly to SYNC if COMMAS_TO_SYNC=1).
REQ-017 In LOSS_OF_SYNC with no comma, valid SHALL stay low and out_paralelo SHALL hold.
REQ-018 In COMMA_DET and SYNC, a symbol boundary SHALL occur only on the enabled edge where bit_cnt==9; there the block SHALL load out_paralelo = sr_n and pulse valid, and pulse comma_det if sr_n is a comma.
REQ-019 COMMA_DET at a boundary: a comma SHALL increment comma_cnt, entering SYNC when it reaches COMMAS_TO_SYNC; an invalid symbol SHALL return to LOSS_OF_SYNC; any other symbol SHALL leave state unchanged.
REQ-020 Commas found off-boundary in COMMA_DET or SYNC SHALL be ignored (no realignment).
REQ-021 SYNC at a boundary: an invalid symbol SHALL increment err_cnt; a valid symbol SHALL clear err_cnt; on err_cnt reaching ERRS_TO_LOSS the FSM SHALL go to LOSS_OF_SYNC and clear err_cnt.
REQ-022 Latency: out_paralelo/valid SHALL reflect a symbol on the same edge that samples its bit j (registered outputs, visible the following cycle).
REQ-023 With ENB=0, sr, bit_cnt, counters, state and out_paralelo SHALL hold, and valid and comma_det SHALL be 0.
REQ-024 The transition into LOSS_OF_SYNC and the comma check of REQ-016 SHALL NOT both act on the same edge; re-search starts on the next enabled edge.
REQ-025 valid and comma_det SHALL be registered single-cycle pulses, never asserted for two consecutive cycles.

Reset
REQ-026 On reset low, asynchronously: sr=0, bit_cnt=0, comma_cnt=0, err_cnt=0, state=LOSS_OF_SYNC, out_paralelo=0, valid=0, comma_det=0, sync=0.
REQ-027 Reset asserted mid-symbol or in SYNC SHALL discard all partial state; after release, alignment restarts per REQ-016.

Verification
REQ-028 Serial stream of 3 leading junk bits (101) then K28.5 RD- -> valid and comma_det pulse on the 13th enabled edge, out_paralelo=0x0FA, state COMMA_DET.
REQ-029 Three K28.5 symbols back-to-back after alignment -> sync rises after the third, symbols then delivered every 10 enabled edges.
REQ-030 In SYNC, send 4 symbols of 10'b0000000011 -> sync drops after the 4th; 3 invalids then one valid D21.5 (0x2AA) -> sync stays high.
REQ-031 In COMMA_DET, send one invalid symbol 10'b1111111111 -> return to LOSS_OF_SYNC, comma_cnt cleared.
REQ-032 Hold ENB=0 for 7 cycles mid-symbol -> no valid pulses, bit_cnt unchanged; symbol completes correctly after ENB returns.
REQ-033 Loopback with encoder -> paraleloserial chain, 8b inputs 0x00..0xFF plus K28.5 -> every out_paralelo matches enc_out_10b in order after sync.
